// File: rtl/demux_stream_router_if.sv
// Bundles the input stream, both routed output streams and the packet counters of
// demux_stream_router. The slave modport is the router's view; master is the environment's.
interface demux_stream_router_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_last;
  logic             sel;
  logic             din_ready;

  logic [WIDTH-1:0] dout_0;
  logic             dout_0_valid;
  logic             dout_0_last;
  logic             dout_0_ready;

  logic [WIDTH-1:0] dout_1;
  logic             dout_1_valid;
  logic             dout_1_last;
  logic             dout_1_ready;

  logic [7:0]       pkt_cnt_0;
  logic [7:0]       pkt_cnt_1;

  modport slave (
    input  din, din_valid, din_last, sel, dout_0_ready, dout_1_ready,
    output din_ready, dout_0, dout_0_valid, dout_0_last,
           dout_1, dout_1_valid, dout_1_last, pkt_cnt_0, pkt_cnt_1
  );

  modport master (
    output din, din_valid, din_last, sel, dout_0_ready, dout_1_ready,
    input  din_ready, dout_0, dout_0_valid, dout_0_last,
           dout_1, dout_1_valid, dout_1_last, pkt_cnt_0, pkt_cnt_1
  );
endinterface

// File: rtl/demux_stream_router.sv
// Packet-aware 1:2 stream demux: the first beat's sel picks the output for the whole packet.
// One output register gives 1-cycle latency with full throughput; per-output packet counters.
module demux_stream_router #(
  parameter int WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  demux_stream_router_if.slave  stream
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic             route_q, route_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             dest_q, dest_d;
  logic             full_q, full_d;
  logic [7:0]       cnt0_q, cnt0_d;
  logic [7:0]       cnt1_q, cnt1_d;

  logic selReady;
  logic handoff;
  logic accept;
  logic outEn0;
  logic outEn1;

  // Only the currently addressed output can stall the register.
  assign selReady = dest_q ? stream.dout_1_ready : stream.dout_0_ready;
  assign handoff  = !rst && full_q && selReady;
  assign stream.din_ready = !rst && (!full_q || selReady);
  assign accept   = stream.din_valid && stream.din_ready;

  // Outputs are forced quiet while rst is high so a held beat is never presented.
  assign outEn0 = !rst && !dest_q;
  assign outEn1 = !rst && dest_q;

  assign stream.dout_0_valid = outEn0 && full_q;
  assign stream.dout_1_valid = outEn1 && full_q;
  assign stream.dout_0       = outEn0 ? data_q : '0;
  assign stream.dout_1       = outEn1 ? data_q : '0;
  assign stream.dout_0_last  = outEn0 && last_q;
  assign stream.dout_1_last  = outEn1 && last_q;
  assign stream.pkt_cnt_0    = rst ? 8'd0 : cnt0_q;
  assign stream.pkt_cnt_1    = rst ? 8'd0 : cnt1_q;

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    data_d  = data_q;
    last_d  = last_q;
    dest_d  = dest_q;
    full_d  = full_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;

    if (accept) begin
      data_d = stream.din;
      last_d = stream.din_last;
      full_d = 1'b1;
      if (state_q == IDLE) begin
        dest_d = stream.sel;
        if (!stream.din_last) begin
          state_d = BUSY;
          route_d = stream.sel;
        end
      end else begin
        dest_d = route_q;
        if (stream.din_last) begin
          state_d = IDLE;
        end
      end
    end else if (handoff) begin
      full_d = 1'b0;
    end

    if (handoff && last_q) begin
      if (dest_q) begin
        cnt1_d = cnt1_q + 8'd1;
      end else begin
        cnt0_d = cnt0_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      route_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      dest_q  <= 1'b0;
      full_q  <= 1'b0;
      cnt0_q  <= 8'd0;
      cnt1_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      data_q  <= data_d;
      last_q  <= last_d;
      dest_q  <= dest_d;
      full_q  <= full_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

endmodule

// File: tb/tb_demux_stream_router.sv
// Scoreboard bench for demux_stream_router: accepted beats are queued with their expected
// destination and checked in order as they hand off; scenario tasks check counters and stalls.
module tb_demux_stream_router;

  typedef struct packed {
    logic       dest;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk;
  logic rst;

  demux_stream_router_if #(.WIDTH(8)) bus ();

  demux_stream_router #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .stream (bus)
  );

  beat_t expQ[$];
  int    checks;
  int    errors;
  logic  tbBusy;
  logic  tbRoute;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every handoff must match the oldest accepted beat; at most one valid at a time.
  always @(negedge clk) begin
    beat_t exp;
    beat_t got;
    logic  [7:0] other;
    if (rst === 1'b0) begin
      checks++;
      if (bus.dout_0_valid && bus.dout_1_valid) begin
        errors++;
        $display("[TB] FAIL one_valid: dout_0_valid=%b dout_1_valid=%b required at most one high",
                 bus.dout_0_valid, bus.dout_1_valid);
      end
      if ((bus.dout_0_valid && bus.dout_0_ready) || (bus.dout_1_valid && bus.dout_1_ready)) begin
        got.dest = bus.dout_1_valid;
        got.data = bus.dout_1_valid ? bus.dout_1 : bus.dout_0;
        got.last = bus.dout_1_valid ? bus.dout_1_last : bus.dout_0_last;
        other    = bus.dout_1_valid ? bus.dout_0 : bus.dout_1;
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_beat: got dest=%0d data=0x%02h last=%b required no beat",
                   got.dest, got.data, got.last);
        end else begin
          exp = expQ.pop_front();
          if (got !== exp) begin
            errors++;
            $display("[TB] FAIL handoff: got dest=%0d data=0x%02h last=%b required dest=%0d data=0x%02h last=%b",
                     got.dest, got.data, got.last, exp.dest, exp.data, exp.last);
          end
          checks++;
          if (other !== 8'h00) begin
            errors++;
            $display("[TB] FAIL idle_output_zero: got 0x%02h required 0x00", other);
          end
        end
      end
    end
  end

  task automatic idleIn();
    bus.din_valid = 1'b0;
    bus.din       = 8'h00;
    bus.din_last  = 1'b0;
    bus.sel       = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst              = 1'b1;
    idleIn();
    bus.dout_0_ready = 1'b1;
    bus.dout_1_ready = 1'b1;
    cycles(2);
    rst     = 1'b0;
    tbBusy  = 1'b0;
    tbRoute = 1'b0;
    expQ.delete();
  endtask

  // Drives one beat until accepted; records its expected destination on acceptance.
  task automatic sendBeat(input logic [7:0] data, input logic last, input logic s);
    beat_t b;
    bit    done;
    done = 1'b0;
    bus.din       = data;
    bus.din_last  = last;
    bus.sel       = s;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.din_ready === 1'b1) begin
        b.dest = tbBusy ? tbRoute : s;
        b.data = data;
        b.last = last;
        expQ.push_back(b);
        if (!tbBusy && !last) begin
          tbBusy  = 1'b1;
          tbRoute = s;
        end else if (tbBusy && last) begin
          tbBusy = 1'b0;
        end
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: beat 0x%02h got no din_ready required acceptance", data);
    end
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 20) begin
      cycles(1);
      n++;
    end
    cycles(1);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: got %0d beats pending required 0", name, expQ.size());
    end
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.dout_0_ready = 1'b1;
    bus.dout_1_ready = 1'b1;
    bus.din_valid    = 1'b1;
    bus.din          = 8'hAA;
    bus.din_last     = 1'b1;
    bus.sel          = 1'b1;
    cycles(2);
    @(negedge clk);
    checks++;
    if (bus.din_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_din_ready: got %b required 0", bus.din_ready);
    end
    checks++;
    if ({bus.dout_0_valid, bus.dout_1_valid, bus.pkt_cnt_0, bus.pkt_cnt_1} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v0=%b v1=%b c0=%0d c1=%0d required all 0",
               bus.dout_0_valid, bus.dout_1_valid, bus.pkt_cnt_0, bus.pkt_cnt_1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idleIn();
    tbBusy  = 1'b0;
    tbRoute = 1'b0;
    expQ.delete();
    @(negedge clk);
    checks++;
    if (bus.din_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_ready: got %b required 1", bus.din_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_three_beat();
    doReset();
    sendBeat(8'hA1, 1'b0, 1'b1);
    sendBeat(8'hA2, 1'b0, 1'b0);
    sendBeat(8'hA3, 1'b1, 1'b0);
    idleIn();
    @(negedge clk);
    checks++;
    if ({bus.dout_1_valid, bus.dout_1, bus.dout_1_last} !== {1'b1, 8'hA3, 1'b1}) begin
      errors++;
      $display("[TB] FAIL three_beat_last: got v=%b d=0x%02h l=%b required v=1 d=0xa3 l=1",
               bus.dout_1_valid, bus.dout_1, bus.dout_1_last);
    end
    waitDrain("three_beat");
    checks++;
    if ({bus.pkt_cnt_0, bus.pkt_cnt_1} !== {8'd0, 8'd1}) begin
      errors++;
      $display("[TB] FAIL three_beat_cnt: got c0=%0d c1=%0d required c0=0 c1=1",
               bus.pkt_cnt_0, bus.pkt_cnt_1);
    end
  endtask

  task automatic test_sel_toggle();
    doReset();
    sendBeat(8'hB1, 1'b0, 1'b0);
    sendBeat(8'hB2, 1'b0, 1'b1);
    sendBeat(8'hB3, 1'b0, 1'b0);
    sendBeat(8'hB4, 1'b1, 1'b1);
    idleIn();
    waitDrain("sel_toggle");
    checks++;
    if ({bus.pkt_cnt_0, bus.pkt_cnt_1} !== {8'd1, 8'd0}) begin
      errors++;
      $display("[TB] FAIL sel_toggle_cnt: got c0=%0d c1=%0d required c0=1 c1=0",
               bus.pkt_cnt_0, bus.pkt_cnt_1);
    end
  endtask

  task automatic test_backpressure();
    beat_t b;
    doReset();
    bus.dout_0_ready = 1'b0;
    bus.dout_1_ready = 1'b1;
    sendBeat(8'h5A, 1'b1, 1'b0);
    bus.din_valid = 1'b1;
    bus.din       = 8'h5B;
    bus.din_last  = 1'b1;
    bus.sel       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.din_ready, bus.dout_0_valid, bus.dout_0} !== {1'b0, 1'b1, 8'h5A}) begin
        errors++;
        $display("[TB] FAIL stall_hold_%0d: got rdy=%b v0=%b d0=0x%02h required rdy=0 v0=1 d0=0x5a",
                 i, bus.din_ready, bus.dout_0_valid, bus.dout_0);
      end
      @(posedge clk);
      #1;
    end
    bus.dout_0_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.din_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release_ready: got %b required 1", bus.din_ready);
    end else begin
      b.dest = 1'b1;
      b.data = 8'h5B;
      b.last = 1'b1;
      expQ.push_back(b);
    end
    @(posedge clk);
    #1;
    idleIn();
    waitDrain("backpressure");
    checks++;
    if ({bus.pkt_cnt_0, bus.pkt_cnt_1} !== {8'd1, 8'd1}) begin
      errors++;
      $display("[TB] FAIL backpressure_cnt: got c0=%0d c1=%0d required c0=1 c1=1",
               bus.pkt_cnt_0, bus.pkt_cnt_1);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    sendBeat(8'h11, 1'b1, 1'b0);
    sendBeat(8'h22, 1'b1, 1'b1);
    idleIn();
    @(negedge clk);
    checks++;
    if ({bus.dout_1_valid, bus.dout_1, bus.dout_0_valid} !== {1'b1, 8'h22, 1'b0}) begin
      errors++;
      $display("[TB] FAIL b2b_second: got v1=%b d1=0x%02h v0=%b required v1=1 d1=0x22 v0=0",
               bus.dout_1_valid, bus.dout_1, bus.dout_0_valid);
    end
    waitDrain("back_to_back");
    checks++;
    if ({bus.pkt_cnt_0, bus.pkt_cnt_1} !== {8'd1, 8'd1}) begin
      errors++;
      $display("[TB] FAIL b2b_cnt: got c0=%0d c1=%0d required c0=1 c1=1",
               bus.pkt_cnt_0, bus.pkt_cnt_1);
    end
  endtask

  task automatic test_wrap();
    doReset();
    for (int i = 0; i < 255; i++) begin
      sendBeat(8'(i), 1'b1, 1'b1);
    end
    idleIn();
    waitDrain("wrap_255");
    checks++;
    if (bus.pkt_cnt_1 !== 8'd255) begin
      errors++;
      $display("[TB] FAIL wrap_255: got %0d required 255", bus.pkt_cnt_1);
    end
    sendBeat(8'hFF, 1'b1, 1'b1);
    idleIn();
    waitDrain("wrap_256");
    checks++;
    if (bus.pkt_cnt_1 !== 8'd0) begin
      errors++;
      $display("[TB] FAIL wrap_256: got %0d required 0", bus.pkt_cnt_1);
    end
    sendBeat(8'h01, 1'b1, 1'b1);
    idleIn();
    waitDrain("wrap_257");
    checks++;
    if ({bus.pkt_cnt_0, bus.pkt_cnt_1} !== {8'd0, 8'd1}) begin
      errors++;
      $display("[TB] FAIL wrap_257: got c0=%0d c1=%0d required c0=0 c1=1",
               bus.pkt_cnt_0, bus.pkt_cnt_1);
    end
  endtask

  task automatic test_reset_mid_packet();
    doReset();
    sendBeat(8'hC1, 1'b0, 1'b1);
    sendBeat(8'hC2, 1'b0, 1'b1);
    rst = 1'b1;
    idleIn();
    expQ.delete();
    tbBusy  = 1'b0;
    tbRoute = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.din_ready, bus.dout_0_valid, bus.dout_1_valid, bus.dout_0, bus.dout_1,
         bus.dout_0_last, bus.dout_1_last, bus.pkt_cnt_0, bus.pkt_cnt_1} !== 37'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got rdy=%b v0=%b v1=%b d0=0x%02h d1=0x%02h c0=%0d c1=%0d required all 0",
               bus.din_ready, bus.dout_0_valid, bus.dout_1_valid, bus.dout_0, bus.dout_1,
               bus.pkt_cnt_0, bus.pkt_cnt_1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    sendBeat(8'hD1, 1'b1, 1'b0);
    idleIn();
    @(negedge clk);
    checks++;
    if ({bus.dout_0_valid, bus.dout_0, bus.dout_1_valid} !== {1'b1, 8'hD1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mid_reset_reroute: got v0=%b d0=0x%02h v1=%b required v0=1 d0=0xd1 v1=0",
               bus.dout_0_valid, bus.dout_0, bus.dout_1_valid);
    end
    waitDrain("reset_mid");
    checks++;
    if ({bus.pkt_cnt_0, bus.pkt_cnt_1} !== {8'd1, 8'd0}) begin
      errors++;
      $display("[TB] FAIL mid_reset_cnt: got c0=%0d c1=%0d required c0=1 c1=0",
               bus.pkt_cnt_0, bus.pkt_cnt_1);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    tbBusy  = 1'b0;
    tbRoute = 1'b0;
    rst     = 1'b1;
    idleIn();
    bus.dout_0_ready = 1'b1;
    bus.dout_1_ready = 1'b1;
    test_reset();
    test_three_beat();
    test_sel_toggle();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_stream_router.md
DEMUX_STREAM_ROUTER -- requirements
Module: demux_stream_router

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of every data port.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset; one clock, synchronous, active-high.
REQ-004 SHALL have port din, input, WIDTH: input stream data beat.
REQ-005 SHALL have port din_valid, input, 1: din beat present.
REQ-006 SHALL have port din_last, input, 1: beat is the final beat of a packet.
REQ-007 SHALL have port sel, input, 1: destination select; meaningful only on a packet's first beat.
REQ-008 SHALL have port din_ready, output, 1: block accepts the din beat this cycle.
REQ-009 SHALL have ports dout_0 / dout_1, output, WIDTH each: routed data for output 0 / 1.
REQ-010 SHALL have ports dout_0_valid / dout_1_valid, output, 1 each: beat present on output 0 / 1.
REQ-011 SHALL have ports dout_0_last / dout_1_last, output, 1 each: presented beat ends its packet.
REQ-012 SHALL have ports dout_0_ready / dout_1_ready, input, 1 each: downstream accepts the beat.
REQ-013 SHALL have ports pkt_cnt_0 / pkt_cnt_1, output, 8 each: packets completed on output 0 / 1.

Function
REQ-014 SHALL accept a beat when din_valid && din_ready are both high at a rising clk edge; a handoff occurs when dout_k_valid && dout_k_ready are both high.
REQ-015 SHALL hold exactly one beat in an output register (data_q, last_q, dest_q, full_q); latency din accept -> dout_k_valid is 1 cycle.
REQ-016 SHALL drive din_ready = !full_q || (dest_q==0 ? dout_0_ready : dout_1_ready), so a full register that is being drained accepts a new beat in the same cycle (full throughput).
REQ-017 SHALL implement a two-state FSM: IDLE (no packet open) and BUSY (packet open, route_q holds destination).
REQ-018 In IDLE, on an accepted beat, SHALL set dest = sel; if din_last=0, go to BUSY with route_q = sel; if din_last=1 (single-beat packet), stay in IDLE.
REQ-019 In BUSY, SHALL set dest = route_q for every accepted beat and ignore sel; an accepted beat with din_last=1 returns the FSM to IDLE.
REQ-020 SHALL assert dout_k_valid = full_q && (dest_q==k) and keep dout_(1-k)_valid low, so at most one output valid is high per cycle.
REQ-021 SHALL drive dout_k = data_q and dout_k_last = last_q when dest_q==k; otherwise SHALL drive dout_k and dout_k_last to 0.
REQ-022 SHALL hold data_q, last_q, dest_q and dout_k_valid stable while dout_k_valid=1 and dout_k_ready=0 (no beat drop, no change).
REQ-023 SHALL clear full_q after a handoff when no new beat is accepted in that cycle; when a beat is both handed off and accepted, full_q stays 1 and the register loads the new beat.
REQ-024 SHALL increment pkt_cnt_k by 1 on each handoff on output k with dout_k_last=1, modulo 256 (255 -> 0 wraps silently).
REQ-025 SHALL ignore din, din_last and sel whenever din_valid=0 or din_ready=0.
REQ-026 SHALL NOT stall on the unselected output: dout_(1-k)_ready has no effect while dest_q==k.

Reset
REQ-027 While rst=1 at a rising edge, SHALL set FSM=IDLE, route_q=0, full_q=0, data_q=0, last_q=0, dest_q=0, pkt_cnt_0=pkt_cnt_1=0.
REQ-028 SHALL drive din_ready=0 in any cycle where rst=1; first acceptance is possible in the first cycle after rst deasserts.
REQ-029 Reset mid-packet or with a held beat SHALL discard that beat and the open packet without presenting it; the next accepted beat SHALL be treated as a first beat.

Verification
REQ-030 Bench: sel=1, 3-beat packet A1,A2,A3 (last on A3), both readys high -> dout_1 shows A1..A3 on consecutive cycles starting 1 cycle after the first accept; dout_0_valid never high; pkt_cnt_1=1.
REQ-031 Bench: sel=0 on beat 1, sel toggles on beats 2-4 of a 4-beat packet -> all 4 beats appear on output 0; pkt_cnt_0=1, pkt_cnt_1=0.
REQ-032 Bench: dest output 0, dout_0_ready held low 3 cycles with a beat held -> din_ready=0, dout_0 value and valid unchanged for 3 cycles; the beat hands off on the cycle ready rises.
REQ-033 Bench: back-to-back single-beat packets 0x11 (sel=0) and 0x22 (sel=1), readys high -> 0x11 on dout_0 in cycle n+1, 0x22 on dout_1 in cycle n+2; pkt_cnt_0=1, pkt_cnt_1=1.
REQ-034 Bench: 256 single-beat packets to output 1 -> pkt_cnt_1 wraps to 0; the 257th packet yields 1.
REQ-035 Bench: assert rst for 1 cycle after beat 2 of a 4-beat packet to output 1 -> all outputs and counters 0 during reset cycle; the next beat with sel=0 routes to output 0.
